// File: rtl/id_ex_hazard_unit.sv
// ============================================================================
// Module   : id_ex_hazard_unit
// Purpose  : Load-use hazard detection against the ID/EX register, PC/IF-ID
//            write enables, ID/EX bubble and MEM-resolved branch flush
//            sequencing. Outputs act in the same cycle the condition is seen.
// Options  : `define HAZ_PERF_CNT_EN to build the saturating stall/flush
//            performance counters; otherwise both counters read 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_hazard_unit #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rt,
    input  logic             idex_mem_read,
    input  logic             idex_reg_write,
    input  logic [4:0]       idex_rt_addr,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             exmem_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The down-counter only ever holds (cycles - 1), so clog2(max) bits suffice.
    localparam int MAX_CYC = (LOAD_STALL_CYCLES > FLUSH_CYCLES) ? LOAD_STALL_CYCLES : FLUSH_CYCLES;
    localparam int REM_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [REM_W-1:0] c_ld_reload = REM_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [REM_W-1:0] c_fl_reload = REM_W'(FLUSH_CYCLES - 1);
    localparam logic [REM_W-1:0] c_rem_one   = REM_W'(1);

    typedef enum logic [1:0] {
        S_RUN        = 2'd0,
        S_LOAD_STALL = 2'd1,
        S_FLUSH      = 2'd2
    } state_t;

    state_t             r_state;
    logic [REM_W-1:0]   r_rem;
    logic               w_hazard;

    // Load in EX whose destination is read by the instruction in ID ($zero excluded).
    always_comb begin
        w_hazard = idex_mem_read && idex_reg_write && (idex_rt_addr != 5'd0) &&
                   ((idex_rt_addr == id_rs_addr) ||
                    (id_uses_rt && (idex_rt_addr == id_rt_addr)));
    end

    // Output decode: reset > branch flush > sequenced state > fresh hazard.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (branch_taken || (r_state == S_FLUSH)) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if ((r_state == S_LOAD_STALL) || w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Multi-cycle stall/flush sequencing; a taken branch always wins and reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_rem   <= '0;
        end else if (branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
                r_state <= S_FLUSH;
                r_rem   <= c_fl_reload;
            end else begin
                r_state <= S_RUN;
                r_rem   <= '0;
            end
        end else begin
            case (r_state)
                S_LOAD_STALL, S_FLUSH: begin
                    if (r_rem == c_rem_one) begin
                        r_state <= S_RUN;
                        r_rem   <= '0;
                    end else begin
                        r_rem   <= r_rem - c_rem_one;
                    end
                end
                default: begin
                    if (w_hazard && (LOAD_STALL_CYCLES > 1)) begin
                        r_state <= S_LOAD_STALL;
                        r_rem   <= c_ld_reload;
                    end else begin
                        r_state <= S_RUN;
                        r_rem   <= '0;
                    end
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating event counters: stalled-PC cycles and taken-branch events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (branch_taken && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_hazard_unit.sv
// ============================================================================
// Module   : tb_id_ex_hazard_unit
// Purpose  : Scoreboard bench for id_ex_hazard_unit. Two instances (3/2/4-bit
//            counters and the 1/1/16 defaults) share stimulus; the driver
//            pushes reference-model expectations, the monitor pops/compares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_hazard_unit;

    localparam logic [4:0] O_NORM  = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00100;
    localparam logic [4:0] O_FLUSH = 5'b11111;
    localparam logic [4:0] O_RESET = 5'b00111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs_addr = '0, id_rt_addr = '0, idex_rt_addr = '0;
    logic       id_uses_rt = 1'b0, idex_mem_read = 1'b0, idex_reg_write = 1'b0;
    logic       branch_taken = 1'b0;

    logic        pcw_a, ifw_a, bub_a, iff_a, exf_a;
    logic        pcw_b, ifw_b, bub_b, iff_b, exf_b;
    logic [3:0]  scnt_a, fcnt_a;
    logic [15:0] scnt_b, fcnt_b;

    always #5 clk = ~clk;

    id_ex_hazard_unit #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .idex_rt_addr(idex_rt_addr), .branch_taken(branch_taken),
        .pc_write(pcw_a), .ifid_write(ifw_a), .idex_bubble(bub_a), .ifid_flush(iff_a),
        .exmem_flush(exf_a), .stall_cnt(scnt_a), .flush_cnt(fcnt_a));

    id_ex_hazard_unit dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rt(id_uses_rt), .idex_mem_read(idex_mem_read), .idex_reg_write(idex_reg_write),
        .idex_rt_addr(idex_rt_addr), .branch_taken(branch_taken),
        .pc_write(pcw_b), .ifid_write(ifw_b), .idex_bubble(bub_b), .ifid_flush(iff_b),
        .exmem_flush(exf_b), .stall_cnt(scnt_b), .flush_cnt(fcnt_b));

    typedef struct {
        int         cyc;
        logic [4:0] o0, o1;
        int         sc0, sc1, fc0, fc1;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model state: remaining forced cycles and event counts per instance.
    int lcyc [2] = '{3, 1};
    int fcyc [2] = '{2, 1};
    int cmax [2] = '{15, 65535};
    int sl [2] = '{0, 0};
    int fl [2] = '{0, 0};
    int sc [2] = '{0, 0};
    int fc [2] = '{0, 0};

    task automatic chk(input string name, input int act, input int exp_v, input int cyc);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp_v);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic mr, input logic rw, input logic [4:0] xrt,
                         input logic bt, input logic rn);
        exp_t       e;
        logic [4:0] o [2];
        int         esc [2];
        int         efc [2];
        logic       haz;
        @(posedge clk);
        #1;
        id_rs_addr = rs; id_rt_addr = rt; id_uses_rt = ur;
        idex_mem_read = mr; idex_reg_write = rw; idex_rt_addr = xrt;
        branch_taken = bt; rst_n = rn;
        cycle++;
        haz = mr && rw && (xrt != 0) && ((xrt == rs) || (ur && (xrt == rt)));
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                sl[i] = 0; fl[i] = 0; sc[i] = 0; fc[i] = 0;
                o[i] = O_RESET;
            end else if (bt) begin
                o[i] = O_FLUSH; fl[i] = fcyc[i] - 1; sl[i] = 0;
            end else if (sl[i] > 0) begin
                o[i] = O_STALL; sl[i]--;
            end else if (fl[i] > 0) begin
                o[i] = O_FLUSH; fl[i]--;
            end else if (haz) begin
                o[i] = O_STALL; sl[i] = lcyc[i] - 1;
            end else begin
                o[i] = O_NORM;
            end
`ifdef HAZ_PERF_CNT_EN
            esc[i] = sc[i]; efc[i] = fc[i];
`else
            esc[i] = 0; efc[i] = 0;
`endif
            if (rn) begin
                if (!o[i][4] && sc[i] < cmax[i]) sc[i]++;
                if (bt && fc[i] < cmax[i]) fc[i]++;
            end
        end
        e.cyc = cycle;
        e.o0 = o[0]; e.o1 = o[1];
        e.sc0 = esc[0]; e.sc1 = esc[1]; e.fc0 = efc[0]; e.fc1 = efc[1];
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    // Monitor: compare what the DUTs present against the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("outs_a", int'({pcw_a, ifw_a, bub_a, iff_a, exf_a}), int'(e.o0), e.cyc);
            chk("outs_b", int'({pcw_b, ifw_b, bub_b, iff_b, exf_b}), int'(e.o1), e.cyc);
            chk("stall_cnt_a", int'(scnt_a), e.sc0, e.cyc);
            chk("stall_cnt_b", int'(scnt_b), e.sc1, e.cyc);
            chk("flush_cnt_a", int'(fcnt_a), e.fc0, e.cyc);
            chk("flush_cnt_b", int'(fcnt_b), e.fc1, e.cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset, then a branch and reset asserted mid-flush
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(2);
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2);
        // lw $5 / add rs=5, hazard held
        for (int k = 0; k < 4; k++) drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        idle(3);
        // no-stall cases: $zero dest, rt not used, plus rt used
        drive(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
        drive(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        drive(5'd5, 5'd1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1);
        drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1);
        drive(5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        idle(3);
        // branch in 2nd cycle of the 3-cycle stall
        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        drive(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
        idle(3);
        // long hazard run saturates the 4-bit stall counter
        for (int k = 0; k < 20; k++) drive(5'd9, 5'd7, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
        idle(2);
        for (int k = 0; k < 18; k++) drive(5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(3);
        // randomized traffic with small address space and occasional reset
        for (int k = 0; k < 400; k++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) != 0));
        end
        idle(2);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0, cycle);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
